pipe_run_ctrl: RTL and testbench

Run controller for the uRISC five-stage pipeline, instantiated inside `top` between the hazard/decode logic and the pipeline registers. It sequences start-up, stalls, flushes, HALT drain and fault shutdown. It drives the PC and IF/ID enables and the IF/ID and ID/EX flushes, and it owns the retired-instruction and cycle counters that the bench reads.

---
 rtl/urisc_pkg.sv | 20 ++
 rtl/pipe_run_ctrl_sat_counter.sv | 19 +
 rtl/pipe_run_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_run_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/urisc_pkg.sv
// Shared uRISC definitions: run-controller state encoding and default sizes.
package urisc_pkg;

  localparam int PIPE_DEPTH_DEF = 5;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    HALTED,
    FAULT
  } run_state_e;

  // Counters only advance while the pipeline is executing or draining.
  function automatic logic is_active(input run_state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/pipe_run_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run controller for the uRISC pipeline: start-up, stall, flush, HALT drain, fault.
// Optional watchdog fault is built only when PIPE_RUN_CTRL_WATCHDOG_EN is defined.
module pipe_run_ctrl
  import urisc_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WDOG_LIMIT = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             halt_id,
  input  logic             err,
  input  logic             retire_valid,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             fault,
  output logic             wdog_to,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DRAIN_W = $clog2(PIPE_DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LEN = DRAIN_W'(PIPE_DEPTH - 2);

  run_state_e         state, state_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_next;
  logic               wdog_hit;
  logic               active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
    end
  end

  // A branch in EX squashes a HALT sitting in ID, so it outranks halt_id.
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        pc_en      = ~hazard;
        ifid_en    = ~hazard;
        ifid_flush = branch_taken;
        idex_flush = hazard | branch_taken | halt_id;
        if (err || wdog_hit) begin
          state_next = FAULT;
        end else if (branch_taken) begin
          state_next = RUN;
        end else if (halt_id && !hazard) begin
          state_next = DRAIN;
          drain_next = DRAIN_LEN;
        end
      end
      DRAIN: begin
        if (err) begin
          state_next = FAULT;
        end else if (drain_cnt == DRAIN_W'(1)) begin
          state_next = HALTED;
        end else begin
          drain_next = drain_cnt - DRAIN_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  assign halted = (state == HALTED);
  assign fault  = (state == FAULT);
  assign active = is_active(state);

`ifdef PIPE_RUN_CTRL_WATCHDOG_EN
  logic wdog_q;

  assign wdog_hit = (state == RUN) && (cycle_count == CNT_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 1'b0;
    end else if (wdog_hit) begin
      wdog_q <= 1'b1;
    end
  end

  assign wdog_to = wdog_q;
`else
  logic unused_wdog;

  assign unused_wdog = (WDOG_LIMIT != 0);
  assign wdog_hit    = 1'b0;
  assign wdog_to     = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_inst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active & retire_valid),
    .count (inst_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl; watchdog scenario runs when PIPE_RUN_CTRL_WATCHDOG_EN is defined.
module tb_pipe_run_ctrl;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, hazard, branch_taken, halt_id, err, retire_valid;
  logic             pc_en, ifid_en, ifid_flush, idex_flush;
  logic             halted, fault, wdog_to;
  logic [CNT_W-1:0] inst_count, cycle_count;

  int assertCount = 0;
  int failCount   = 0;

  pipe_run_ctrl #(
    .PIPE_DEPTH (5),
    .CNT_W      (CNT_W),
    .WDOG_LIMIT (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .halt_id      (halt_id),
    .err          (err),
    .retire_valid (retire_valid),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .halted       (halted),
    .fault        (fault),
    .wdog_to      (wdog_to),
    .inst_count   (inst_count),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic hz, input logic br,
                               input logic hl, input logic er, input logic rv);
    start        = s;
    hazard       = hz;
    branch_taken = br;
    halt_id      = hl;
    err          = er;
    retire_valid = rv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_pc_en", pc_en, 0);
    checkOutput("rst_ifid_en", ifid_en, 0);
    checkOutput("rst_ifid_flush", ifid_flush, 1);
    checkOutput("rst_idex_flush", idex_flush, 1);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_wdog_to", wdog_to, 0);
    checkOutput("rst_inst", inst_count, 0);
    checkOutput("rst_cycle", cycle_count, 0);
    rst_n = 1'b1;

    // Start-up, two-cycle stall, then HALT drain with retirements.
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1 checkOutput("idle_pc_en", pc_en, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("run_pc_en", pc_en, 1);
    checkOutput("run_ifid_en", ifid_en, 1);
    checkOutput("run_ifid_flush", ifid_flush, 0);
    checkOutput("run_idex_flush", idex_flush, 0);
    checkOutput("run_inst0", inst_count, 0);
    checkOutput("run_cycle0", cycle_count, 0);
    tick();
    checkOutput("run_cycle1", cycle_count, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      #1;
      checkOutput("haz_pc_en", pc_en, 0);
      checkOutput("haz_ifid_en", ifid_en, 0);
      checkOutput("haz_idex_flush", idex_flush, 1);
      checkOutput("haz_ifid_flush", ifid_flush, 0);
      tick();
    end
    checkOutput("haz_cycle", cycle_count, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("post_haz_pc_en", pc_en, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("halt_idex_flush", idex_flush, 1);
    checkOutput("halt_pc_en", pc_en, 1);
    tick();
    checkOutput("drain_cycle", cycle_count, 4);
    applyStimulus(0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("drain_pc_en", pc_en, 0);
    checkOutput("drain_ifid_flush", ifid_flush, 1);
    checkOutput("drain_idex_flush", idex_flush, 1);
    tick();
    checkOutput("drain1_inst", inst_count, 1);
    checkOutput("drain1_halted", halted, 0);
    tick();
    checkOutput("drain2_inst", inst_count, 2);
    checkOutput("drain2_halted", halted, 0);
    tick();
    checkOutput("halted_flag", halted, 1);
    checkOutput("halted_inst", inst_count, 3);
    checkOutput("halted_cycle", cycle_count, 7);
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1 checkOutput("halted_pc_en", pc_en, 0);
    repeat (2) tick();
    checkOutput("halted_sticky", halted, 1);
    checkOutput("halted_cycle_frozen", cycle_count, 7);
    checkOutput("halted_no_fault", fault, 0);

    // Branch squashes HALT, stalled HALT waits, then err during DRAIN faults.
    applyStimulus(0, 0, 0, 0, 0, 0);
    resetPulse();
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 0);
    #1;
    checkOutput("br_ifid_flush", ifid_flush, 1);
    checkOutput("br_idex_flush", idex_flush, 1);
    checkOutput("br_pc_en", pc_en, 1);
    tick();
    applyStimulus(0, 1, 0, 1, 0, 0);
    #1;
    checkOutput("hzhalt_pc_en", pc_en, 0);
    checkOutput("hzhalt_idex_flush", idex_flush, 1);
    tick();
    checkOutput("hzhalt_halted", halted, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("still_run_pc_en", pc_en, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    #1 checkOutput("drain_err_pc_en", pc_en, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("fault_flag", fault, 1);
    checkOutput("fault_halted", halted, 0);
    checkOutput("fault_pc_en", pc_en, 0);
    checkOutput("fault_ifid_flush", ifid_flush, 1);
    checkOutput("fault_cycle", cycle_count, 4);
    repeat (2) tick();
    checkOutput("fault_sticky", fault, 1);
    checkOutput("fault_cycle_frozen", cycle_count, 4);

    // Retirements in RUN, then asynchronous reset mid-RUN.
    applyStimulus(0, 0, 0, 0, 0, 0);
    resetPulse();
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    checkOutput("retire_inst", inst_count, 4);
    checkOutput("retire_cycle", cycle_count, 4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_inst", inst_count, 0);
    checkOutput("async_cycle", cycle_count, 0);
    checkOutput("async_pc_en", pc_en, 0);
    checkOutput("async_idex_flush", idex_flush, 1);
    tick();
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1);
    tick();
    checkOutput("run_err_fault", fault, 1);
    checkOutput("run_err_inst", inst_count, 1);
    checkOutput("run_err_wdog", wdog_to, 0);

    applyStimulus(0, 0, 0, 0, 0, 0);
    resetPulse();
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
`ifdef PIPE_RUN_CTRL_WATCHDOG_EN
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (19) tick();
    checkOutput("wdog_pre_fault", fault, 0);
    checkOutput("wdog_pre_cycle", cycle_count, 19);
    tick();
    checkOutput("wdog_fault", fault, 1);
    checkOutput("wdog_to", wdog_to, 1);
    checkOutput("wdog_cycle", cycle_count, 20);
    checkOutput("wdog_pc_en", pc_en, 0);
`else
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (35) tick();
    checkOutput("nowdog_wdog_to", wdog_to, 0);
    checkOutput("nowdog_fault", fault, 0);
    checkOutput("sat_cycle", cycle_count, 31);
    checkOutput("sat_inst", inst_count, 31);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
